// File: rtl/ecc_cache_sram_responder_if.sv
// Request/response bundle between the dcache ECC arbiter (master) and the codeword SRAM responder (slave).
// Carries the banked SRAM access, the fault-injection port and the read-error monitor outputs.
interface ecc_cache_sram_responder_if #(
    parameter int unsigned NR_WAYS    = 8,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned LINE_W = DATA_BYTES * 13;
    localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
    localparam int unsigned WAY_W  = $clog2(NR_WAYS);
    localparam int unsigned BIT_W  = $clog2(LINE_W);

    logic [NR_WAYS-1:0]             req_i;
    logic                           we_i;
    logic [ADDR_W-1:0]              addr_i;
    logic [LINE_W-1:0]              wdata_i;
    logic [DATA_BYTES-1:0]          be_i;
    logic [NR_WAYS-1:0][LINE_W-1:0] rdata_o;
    logic                           inj_valid_i;
    logic [WAY_W-1:0]               inj_way_i;
    logic [ADDR_W-1:0]              inj_addr_i;
    logic [BIT_W-1:0]               inj_bit_i;
    logic                           inj_ack_o;
    logic                           err_clr_i;
    logic [CNT_WIDTH-1:0]           ce_cnt_o;
    logic [CNT_WIDTH-1:0]           ue_cnt_o;
    logic                           err_valid_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        output inj_valid_i, inj_way_i, inj_addr_i, inj_bit_i, err_clr_i,
        input  rdata_o, inj_ack_o, ce_cnt_o, ue_cnt_o, err_valid_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        input  inj_valid_i, inj_way_i, inj_addr_i, inj_bit_i, err_clr_i,
        output rdata_o, inj_ack_o, ce_cnt_o, ue_cnt_o, err_valid_o
    );
endinterface

// File: rtl/ecc_cache_sram_responder.sv
// Banked Hsiao-codeword SRAM with bit-flip injection and a saturating CE/UE read monitor.
// One-cycle read latency; no backpressure, every request is accepted (colliding injections are nacked).
module ecc_cache_sram_responder #(
    parameter int unsigned NR_WAYS    = 8,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    ecc_cache_sram_responder_if.slave bus
);
    localparam int unsigned CW_W   = 13;
    localparam int unsigned LINE_W = DATA_BYTES * CW_W;
    localparam int unsigned SUM_W  = $clog2(NR_WAYS * DATA_BYTES + 1);
    localparam int unsigned ADD_W  = ((CNT_WIDTH > SUM_W) ? CNT_WIDTH : SUM_W) + 1;
    localparam logic [ADD_W-1:0] CNT_MAX = ADD_W'({CNT_WIDTH{1'b1}});

    // Data bits covered by each of the 5 check bits; every data column has odd weight 3.
    localparam logic [4:0][7:0] CHK_MASK = {8'hF0, 8'h8E, 8'h6D, 8'h5B, 8'hB7};

    typedef logic [LINE_W-1:0] line_t;

    // Returns {ue, ce}: odd-weight syndrome is a single-bit error, nonzero even weight is a double.
    function automatic logic [1:0] hsiao_ecc_dec(input logic [CW_W-1:0] cw);
        logic [4:0] syn;
        for (int j = 0; j < 5; j++) begin
            syn[j] = cw[8+j] ^ (^(cw[7:0] & CHK_MASK[j]));
        end
        return {(|syn) & ~(^syn), ^syn};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [SUM_W-1:0]     num,
                                                     input logic                 clr);
        logic [ADD_W-1:0] sum;
        sum = (clr ? '0 : ADD_W'(cnt)) + ADD_W'(num);
        return (sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
    endfunction

    line_t                          mem_q [NR_WAYS][NUM_WORDS];
    logic [NR_WAYS-1:0][LINE_W-1:0] rdata_d, rdata_q;
    logic                           stage_vld_d, stage_vld_q;
    logic [NR_WAYS-1:0]             stage_mask_d, stage_mask_q;
    logic [CNT_WIDTH-1:0]           ce_cnt_d, ce_cnt_q;
    logic [CNT_WIDTH-1:0]           ue_cnt_d, ue_cnt_q;
    logic [SUM_W-1:0]               ce_num, ue_num;
    logic [1:0]                     err_byte;
    logic                           inj_ack;
    logic                           err_valid;

    // A write to the exact target line wins; the injector must retry.
    assign inj_ack = bus.inj_valid_i
                   & ~(bus.req_i[bus.inj_way_i] & bus.we_i & (bus.addr_i == bus.inj_addr_i));

    // Storage is not reset; the write and an acked flip never touch the same line in one cycle.
    always_ff @(posedge clk_i) begin
        for (int unsigned w = 0; w < NR_WAYS; w++) begin
            if (bus.req_i[w] && bus.we_i) begin
                for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                    if (bus.be_i[b]) begin
                        mem_q[w][bus.addr_i][b*CW_W +: CW_W] <= bus.wdata_i[b*CW_W +: CW_W];
                    end
                end
            end
        end
        if (inj_ack && (int'(bus.inj_bit_i) < int'(LINE_W))) begin
            mem_q[bus.inj_way_i][bus.inj_addr_i][bus.inj_bit_i] <=
                ~mem_q[bus.inj_way_i][bus.inj_addr_i][bus.inj_bit_i];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        for (int unsigned w = 0; w < NR_WAYS; w++) begin
            if (bus.req_i[w] && !bus.we_i) begin
                rdata_d[w] = mem_q[w][bus.addr_i];
            end
        end
        stage_mask_d = bus.req_i & {NR_WAYS{~bus.we_i}};
        stage_vld_d  = |stage_mask_d;
    end

    // Monitor decodes the registered read data, so counts land the cycle after the read.
    always_comb begin
        ce_num   = '0;
        ue_num   = '0;
        err_byte = '0;
        for (int unsigned w = 0; w < NR_WAYS; w++) begin
            for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                if (stage_vld_q && stage_mask_q[w]) begin
                    err_byte = hsiao_ecc_dec(rdata_q[w][b*CW_W +: CW_W]);
                    ce_num   = ce_num + SUM_W'(err_byte[0]);
                    ue_num   = ue_num + SUM_W'(err_byte[1]);
                end
            end
        end
        err_valid = (ce_num != '0) || (ue_num != '0);
        ce_cnt_d  = sat_add(ce_cnt_q, ce_num, bus.err_clr_i);
        ue_cnt_d  = sat_add(ue_cnt_q, ue_num, bus.err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q      <= '0;
            stage_vld_q  <= 1'b0;
            stage_mask_q <= '0;
            ce_cnt_q     <= '0;
            ue_cnt_q     <= '0;
        end else begin
            rdata_q      <= rdata_d;
            stage_vld_q  <= stage_vld_d;
            stage_mask_q <= stage_mask_d;
            ce_cnt_q     <= ce_cnt_d;
            ue_cnt_q     <= ue_cnt_d;
        end
    end

    assign bus.rdata_o     = rdata_q;
    assign bus.inj_ack_o   = inj_ack;
    assign bus.ce_cnt_o    = ce_cnt_q;
    assign bus.ue_cnt_o    = ue_cnt_q;
    assign bus.err_valid_o = err_valid;
endmodule

// File: tb/tb_ecc_cache_sram_responder.sv
// Directed bench for ecc_cache_sram_responder: read/write, byte enables, injection, CE/UE counting.
// Counters are built 4 bits wide so saturation is reachable with a short run.
module tb_ecc_cache_sram_responder;
    localparam int NW   = 8;
    localparam int NWDS = 256;
    localparam int DB   = 4;
    localparam int CNTW = 4;
    localparam int LW   = DB * 13;

    typedef logic [LW-1:0] line_t;

    // Hsiao H-matrix data columns (check-bit pattern of each data bit).
    localparam logic [4:0] COLS [8] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110,
                                        5'b10011, 5'b10101, 5'b10110, 5'b11001};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    ecc_cache_sram_responder_if #(.NR_WAYS(NW), .NUM_WORDS(NWDS), .DATA_BYTES(DB), .CNT_WIDTH(CNTW)) bus ();

    ecc_cache_sram_responder #(.NR_WAYS(NW), .NUM_WORDS(NWDS), .DATA_BYTES(DB), .CNT_WIDTH(CNTW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] enc8(input logic [7:0] d);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (d[i]) p = p ^ COLS[i];
        return {p, d};
    endfunction

    function automatic line_t enc_line(input logic [31:0] d);
        line_t l;
        for (int b = 0; b < DB; b++) l[b*13 +: 13] = enc8(d[b*8 +: 8]);
        return l;
    endfunction

    function automatic logic [31:0] dec_line(input line_t l);
        logic [31:0] d;
        logic [12:0] cw, re;
        logic [4:0]  syn;
        logic [7:0]  db;
        for (int b = 0; b < DB; b++) begin
            cw  = l[b*13 +: 13];
            re  = enc8(cw[7:0]);
            syn = cw[12:8] ^ re[12:8];
            db  = cw[7:0];
            for (int i = 0; i < 8; i++) if (syn == COLS[i]) db[i] = ~db[i];
            d[b*8 +: 8] = db;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.req_i       = '0;
        bus.we_i        = 1'b0;
        bus.addr_i      = '0;
        bus.wdata_i     = '0;
        bus.be_i        = '0;
        bus.inj_valid_i = 1'b0;
        bus.inj_way_i   = '0;
        bus.inj_addr_i  = '0;
        bus.inj_bit_i   = '0;
        bus.err_clr_i   = 1'b0;
    endtask

    task automatic drive_wr(input logic [NW-1:0] ways, input logic [7:0] addr,
                            input line_t data, input logic [DB-1:0] be);
        idle();
        bus.req_i   = ways;
        bus.we_i    = 1'b1;
        bus.addr_i  = addr;
        bus.wdata_i = data;
        bus.be_i    = be;
    endtask

    task automatic drive_rd(input logic [NW-1:0] ways, input logic [7:0] addr);
        idle();
        bus.req_i  = ways;
        bus.addr_i = addr;
    endtask

    task automatic drive_inj(input logic [2:0] way, input logic [7:0] addr, input logic [5:0] bitn);
        bus.inj_valid_i = 1'b1;
        bus.inj_way_i   = way;
        bus.inj_addr_i  = addr;
        bus.inj_bit_i   = bitn;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_rdata", 64'(|bus.rdata_o), 64'd0);
        check_eq("rst_ce", 64'(bus.ce_cnt_o), 64'd0);
        check_eq("rst_ue", 64'(bus.ue_cnt_o), 64'd0);
        check_eq("rst_errv", 64'(bus.err_valid_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Clean write then read on way 2.
        drive_wr(8'h04, 8'd5, enc_line(32'hDEADBEEF), 4'hF); tick();
        drive_rd(8'h04, 8'd5); tick();
        check_eq("rd_clean", 64'(bus.rdata_o[2]), 64'(enc_line(32'hDEADBEEF)));
        check_eq("rd_clean_errv", 64'(bus.err_valid_o), 64'd0);
        idle(); tick();
        check_eq("rd_hold", 64'(bus.rdata_o[2]), 64'(enc_line(32'hDEADBEEF)));
        check_eq("clean_ce", 64'(bus.ce_cnt_o), 64'd0);
        check_eq("clean_ue", 64'(bus.ue_cnt_o), 64'd0);

        // Byte-enable merge on way 3.
        drive_wr(8'h08, 8'd9, enc_line(32'h11223344), 4'hF); tick();
        drive_wr(8'h08, 8'd9, enc_line(32'hFFFFFFFF), 4'b0010); tick();
        drive_rd(8'h08, 8'd9); tick();
        check_eq("be_merge", 64'(dec_line(bus.rdata_o[3])), 64'h1122FF44);

        // Single flip -> one CE, data still correctable.
        idle(); drive_inj(3'd2, 8'd5, 6'd3); #1;
        check_eq("inj_ack_ce", 64'(bus.inj_ack_o), 64'd1);
        tick();
        drive_rd(8'h04, 8'd5); tick();
        check_eq("ce_errv", 64'(bus.err_valid_o), 64'd1);
        check_eq("ce_data", 64'(dec_line(bus.rdata_o[2])), 64'hDEADBEEF);
        idle(); tick();
        check_eq("ce_cnt1", 64'(bus.ce_cnt_o), 64'd1);
        check_eq("ce_errv_pulse", 64'(bus.err_valid_o), 64'd0);

        // Second flip in the same byte -> one UE.
        idle(); drive_inj(3'd2, 8'd5, 6'd4); tick();
        drive_rd(8'h04, 8'd5); tick();
        check_eq("ue_errv", 64'(bus.err_valid_o), 64'd1);
        idle(); tick();
        check_eq("ue_cnt1", 64'(bus.ue_cnt_o), 64'd1);
        check_eq("ue_ce_same", 64'(bus.ce_cnt_o), 64'd1);

        // Write/injection collision, retry alongside a read of the same line.
        drive_wr(8'h02, 8'd7, enc_line(32'hCAFEF00D), 4'hF);
        drive_inj(3'd1, 8'd7, 6'd0); #1;
        check_eq("coll_ack", 64'(bus.inj_ack_o), 64'd0);
        tick();
        drive_rd(8'h02, 8'd7);
        drive_inj(3'd1, 8'd7, 6'd0); #1;
        check_eq("retry_ack", 64'(bus.inj_ack_o), 64'd1);
        tick();
        check_eq("coll_preflip", 64'(bus.rdata_o[1]), 64'(enc_line(32'hCAFEF00D)));
        drive_rd(8'h02, 8'd7); tick();
        check_eq("coll_postflip", 64'(bus.rdata_o[1]), 64'(enc_line(32'hCAFEF00D) ^ line_t'(1)));
        idle(); drive_inj(3'd1, 8'd7, 6'd60); #1;
        check_eq("oob_ack", 64'(bus.inj_ack_o), 64'd1);
        tick();
        drive_rd(8'h02, 8'd7); tick();
        check_eq("oob_ignored", 64'(bus.rdata_o[1]), 64'(enc_line(32'hCAFEF00D) ^ line_t'(1)));
        idle(); tick();
        check_eq("ce_cnt3", 64'(bus.ce_cnt_o), 64'd3);

        idle(); bus.err_clr_i = 1'b1; tick();
        idle();
        check_eq("clr_ce", 64'(bus.ce_cnt_o), 64'd0);
        check_eq("clr_ue", 64'(bus.ue_cnt_o), 64'd0);

        // Saturation: 15 CEs in one all-way read, then one more.
        drive_wr(8'hFF, 8'd20, enc_line(32'h01020304), 4'hF); tick();
        for (int w = 0; w < NW; w++) begin
            idle(); drive_inj(3'(w), 8'd20, 6'd0); tick();
        end
        for (int w = 0; w < NW - 1; w++) begin
            idle(); drive_inj(3'(w), 8'd20, 6'd13); tick();
        end
        drive_rd(8'hFF, 8'd20); tick();
        check_eq("multi_wr", 64'(bus.rdata_o[5]), 64'(enc_line(32'h01020304) ^ line_t'(52'h2001)));
        idle(); tick();
        check_eq("sat_fill", 64'(bus.ce_cnt_o), 64'd15);
        drive_rd(8'h80, 8'd20); tick();
        idle(); tick();
        check_eq("sat_hold", 64'(bus.ce_cnt_o), 64'd15);
        drive_rd(8'h01, 8'd20); tick();
        idle(); bus.err_clr_i = 1'b1; tick();
        idle();
        check_eq("clr_add", 64'(bus.ce_cnt_o), 64'd2);

        // Asynchronous reset with a read in flight.
        drive_rd(8'h04, 8'd5); tick();
        idle();
        rst_ni = 1'b0; #1;
        check_eq("arst_rdata", 64'(bus.rdata_o[2]), 64'd0);
        check_eq("arst_errv", 64'(bus.err_valid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        tick();
        check_eq("arst_ue", 64'(bus.ue_cnt_o), 64'd0);
        check_eq("arst_ce", 64'(bus.ce_cnt_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ecc_cache_sram_responder.md
Name: ecc_cache_sram_responder

Overview:
- Memory-side responder for the ECC-protected dcache arbiter.
- Receives per-way requests carrying Hsiao SEC-DED codewords: 13 bits per data byte, produced by per-byte hsiao_ecc_enc with DataWidth 8.
- Stores the codewords in NR_WAYS banks and returns raw codewords one cycle later.
- Also provides a bit-flip fault-injection port and a read-side error monitor (per-byte hsiao_ecc_dec) with saturating corrected/uncorrectable counters, so scrubbing can be exercised.

Parameters:
- NR_WAYS, 8, number of banks (set-associative ways).
- NUM_WORDS, 256, lines per bank.
- DATA_BYTES, 4, data bytes per line; each byte is stored as one 13-bit codeword.
- CNT_WIDTH, 16, width of the error counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NR_WAYS  per-way access request.
- we_i  in  1  write enable, shared by all requested ways.
- addr_i  in  $clog2(NUM_WORDS)  line index.
- wdata_i  in  DATA_BYTES*13  codeword line to write.
- be_i  in  DATA_BYTES  per-codeword write enable.
- rdata_o  out  NR_WAYS x DATA_BYTES*13  registered read codewords per way.
- inj_valid_i  in  1  fault-injection request.
- inj_way_i  in  $clog2(NR_WAYS)  target bank.
- inj_addr_i  in  $clog2(NUM_WORDS)  target line.
- inj_bit_i  in  $clog2(DATA_BYTES*13)  bit to flip.
- inj_ack_o  out  1  combinational; injection accepted this cycle.
- err_clr_i  in  1  synchronous clear of both counters.
- ce_cnt_o  out  CNT_WIDTH  corrected (single-bit) byte errors seen on reads.
- ue_cnt_o  out  CNT_WIDTH  uncorrectable (double-bit) byte errors seen on reads.
- err_valid_o  out  1  pulse: the previous read had at least one error.

Behaviour:
- Reset values:
  - rdata_o all 0; counters 0; err_valid_o 0.
  - Storage content after reset is undefined. The bench must write before reading, or use the bench-only init to all-zero codewords (all-zero is a valid Hsiao codeword).
- Read:
  - req_i[w]=1 and we_i=0 in cycle N: rdata_o[w] shows mem[w][addr_i] in cycle N+1.
  - rdata_o[w] holds its value when req_i[w]=0.
- Write:
  - req_i[w]=1 and we_i=1: for each b with be_i[b]=1, mem[w][addr_i][b*13+:13] <= wdata_i[b*13+:13] at the clock edge.
  - rdata_o[w] is unchanged by a write (no write-through).
  - Multiple ways may be written in the same cycle with identical data.
- Fault injection:
  - inj_ack_o = inj_valid_i & ~(req_i[inj_way_i] & we_i & (addr_i==inj_addr_i)).
  - When inj_ack_o=1, bit inj_bit_i of mem[inj_way_i][inj_addr_i] is XOR-flipped at the edge.
  - A colliding write has priority: the injection is dropped (ack low) and the requester retries.
  - A read colliding with an injection returns the pre-flip value; the flip is visible to the next read.
  - inj_bit_i >= DATA_BYTES*13 is ignored, ack still 1.
- Error monitor:
  - Stage register: a valid bit plus a way mask, capturing the req_i & ~we_i ways of cycle N.
  - In cycle N+1, rdata_o of each captured way is decoded per byte with hsiao_ecc_dec.
  - Count in N+1: number of (way, byte) pairs with err_o[0] (CE) and with err_o[1] (UE).
  - Each counter adds its count in N+1, saturating at 2^CNT_WIDTH-1 (no wrap).
  - err_valid_o=1 in N+1 iff either count is nonzero.
- Counter clear:
  - err_clr_i clears both counters.
  - If err_clr_i coincides with new errors, the counters load the new count (clear then add).
- Reset mid-operation: async clear of all registered outputs and the monitor stage. Pending reads produce no data and no counts.
- Timing: one-cycle read latency, no backpressure; every request is accepted.

Test Plan:
- Write way 2, addr 5, enc(0xDEADBEEF), be=4'hF; read next cycle -> rdata_o[2] = encoded line in cycle N+1; ce/ue stay 0; err_valid_o 0.
- Write enc(0x11223344); rewrite with be=4'b0010 and enc(0xFFFFFFFF) -> decoded readback 0x1122FF44.
- Inject bit 3 on way 2, addr 5, then read -> inj_ack_o 1; ce_cnt_o 0->1; err_valid_o pulses one cycle; decoded data still 0xDEADBEEF.
- Inject bits 3 and 4 (same byte) on separate cycles, then read -> ue_cnt_o increments by 1.
- Inject on way 1, addr 7 in the same cycle as a write to way 1, addr 7 -> inj_ack_o 0; stored data equals the write; a retry next cycle is acked.
- With CNT_WIDTH=4, preload 15 CEs, then one more CE read -> ce_cnt_o stays 15; err_clr_i in the same cycle as a 2-CE read -> ce_cnt_o = 2.
